// File: rtl/gf180mcu_osu_sc_9t_cell_bist.sv
// Exhaustive-pattern BIST sequencer for a combinational cell: sweeps STIM, folds RESP into a MISR, flags PASS.
// Optional golden truth-table check enabled by defining GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN.
module gf180mcu_osu_sc_9t_cell_bist #(
  parameter int                         NIN    = 2,
  parameter int                         NOUT   = 1,
  parameter int                         MISR_W = 16,
  parameter logic [MISR_W-1:0]          POLY   = 16'h1021,
  parameter logic [MISR_W-1:0]          SEED   = 16'hFFFF,
  parameter int                         SETTLE = 2,
  parameter logic [NOUT*(2**NIN)-1:0]   TT     = 4'b0001
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic [MISR_W-1:0] EXP_SIG,
  input  logic [NOUT-1:0]   RESP,
  output logic [NIN-1:0]    STIM,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIG
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
  ,
  output logic [NIN:0]      ERR_CNT,
  output logic [NIN-1:0]    FIRST_FAIL
`endif
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [NIN:0] LAST_PAT = (NIN+1)'((2**NIN) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            r_state;
  logic [NIN-1:0]    r_stim;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [MISR_W-1:0] r_sig;
  logic [SW-1:0]     r_settle;
  logic [NIN:0]      r_pat;

  logic              w_sample;
  logic [NIN:0]      w_pat_inc;
  logic [MISR_W-1:0] w_sig_next;
  logic              w_pass_next;

  assign w_sample   = (r_settle == SW'(SETTLE - 1));
  assign w_pat_inc  = r_pat + 1'b1;
  assign w_sig_next = {r_sig[MISR_W-2:0], 1'b0}
                    ^ (r_sig[MISR_W-1] ? POLY : '0)
                    ^ MISR_W'(RESP);

`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
  logic [NIN:0]   r_err_cnt;
  logic [NIN-1:0] r_first_fail;
  logic           w_mism;
  logic [NIN:0]   w_err_next;

  assign w_mism      = (RESP != TT[r_pat[NIN-1:0]*NOUT +: NOUT]);
  // Saturate rather than wrap so a full-fail sweep can never read back as clean.
  assign w_err_next  = (w_mism && (r_err_cnt != '1)) ? r_err_cnt + 1'b1 : r_err_cnt;
  assign w_pass_next = (w_sig_next == EXP_SIG) && (w_err_next == '0);
  assign ERR_CNT     = r_err_cnt;
  assign FIRST_FAIL  = r_first_fail;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else if ((r_state != S_RUN) && START) begin
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else if ((r_state == S_RUN) && w_sample) begin
      r_err_cnt <= w_err_next;
      if (w_mism && (r_err_cnt == '0))
        r_first_fail <= r_pat[NIN-1:0];
    end
  end
`else
  logic w_unused_tt;
  assign w_unused_tt = ^TT;
  assign w_pass_next = (w_sig_next == EXP_SIG);
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state  <= S_IDLE;
      r_stim   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_sig    <= SEED;
      r_settle <= '0;
      r_pat    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (START) begin
            r_state  <= S_RUN;
            r_stim   <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_sig    <= SEED;
            r_settle <= '0;
            r_pat    <= '0;
          end
        end
        S_RUN: begin
          if (w_sample) begin
            r_sig    <= w_sig_next;
            r_settle <= '0;
            if (r_pat == LAST_PAT) begin
              // Verdict is latched once here; later EXP_SIG changes cannot disturb it.
              r_state <= S_FIN;
              r_pat   <= '0;
              r_stim  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_next;
            end else begin
              r_pat  <= w_pat_inc;
              r_stim <= w_pat_inc[NIN-1:0];
            end
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign STIM = r_stim;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign SIG  = r_sig;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_cell_bist.sv
// Scoreboard bench: stimulus pushes expected STIM sequences and sweep results; monitors pop and compare.
module tb_gf180mcu_osu_sc_9t_cell_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] exp_sig_a, exp_sig_b, sig_a, sig_b;
  logic [7:0]  tt_a, tt_b;
  logic        resp_a, resp_b;
  logic [1:0]  stim_a;
  logic [2:0]  stim_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
  logic [2:0]  err_a;
  logic [1:0]  ff_a;
  logic [3:0]  err_b;
  logic [2:0]  ff_b;
`endif

  // Behavioural cell under test: its truth table is chosen per sweep.
  assign resp_a = tt_a[stim_a];
  assign resp_b = tt_b[stim_b];

  gf180mcu_osu_sc_9t_cell_bist u_dut_a (
    .CLK(clk), .RN(rst_n), .START(start_a), .EXP_SIG(exp_sig_a), .RESP(resp_a),
    .STIM(stim_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a)
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
    , .ERR_CNT(err_a), .FIRST_FAIL(ff_a)
`endif
  );

  gf180mcu_osu_sc_9t_cell_bist #(.NIN(3), .SETTLE(1), .TT(8'h01)) u_dut_b (
    .CLK(clk), .RN(rst_n), .START(start_b), .EXP_SIG(exp_sig_b), .RESP(resp_b),
    .STIM(stim_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b)
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
    , .ERR_CNT(err_b), .FIRST_FAIL(ff_b)
`endif
  );

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          cycles;
    int          err;
    int          ff;
  } exp_t;

  exp_t exp_q_a[$], exp_q_b[$];
  int   stim_q_a[$], stim_q_b[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no expected event, required one within bound", name);
  endtask

  // Reference: signature is the response polynomial reduced modulo x^16+x^12+x^5+1,
  // golden errors come from comparing the chosen table against the cell's ideal NOR table.
  function automatic exp_t model(input int nin, input int settle, input logic [7:0] tt,
                                 input logic [15:0] es);
    exp_t e;
    int s;
    logic [7:0] golden;
    golden = 8'h01;
    s = 'hFFFF;
    e.err = 0;
    e.ff  = 0;
    for (int p = 0; p < (1 << nin); p++) begin
      s = (s << 1) ^ int'(tt[p]);
      if (s >= 'h10000) s = s ^ 'h11021;
      if (tt[p] != golden[p]) begin
        if (e.err == 0) e.ff = p;
        e.err++;
      end
    end
    e.sig    = s[15:0];
    e.cycles = settle * (1 << nin);
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
    e.pass = (e.sig == es) && (e.err == 0);
`else
    e.pass = (e.sig == es);
`endif
    return e;
  endfunction

  task automatic push_a(input logic [7:0] tt, input logic [15:0] es);
    tt_a = tt;
    exp_sig_a = es;
    for (int p = 0; p < 4; p++) begin
      stim_q_a.push_back(p);
      stim_q_a.push_back(p);
    end
    exp_q_a.push_back(model(2, 2, tt, es));
  endtask

  task automatic launch_a(input logic [7:0] tt, input logic [15:0] es);
    push_a(tt, es);
    start_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic launch_b(input logic [7:0] tt, input logic [15:0] es);
    tt_b = tt;
    exp_sig_b = es;
    for (int p = 0; p < 8; p++) stim_q_b.push_back(p);
    exp_q_b.push_back(model(3, 1, tt, es));
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_a) fail_now("timeout_done_a");
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (!done_b && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_b) fail_now("timeout_done_b");
  endtask

  // Monitor A: one STIM check per BUSY cycle, one result check per DONE rise.
  int   busy_cnt_a = 0;
  logic done_prev_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_a) begin
      busy_cnt_a++;
      if (stim_q_a.size() == 0) fail_now("stim_a_unexpected");
      else check("stim_a", 32'(stim_a), 32'(stim_q_a.pop_front()));
    end
    if (done_a && !done_prev_a) begin
      if (exp_q_a.size() == 0) fail_now("result_a_unexpected");
      else begin
        e = exp_q_a.pop_front();
        check("sig_a", 32'(sig_a), 32'(e.sig));
        check("pass_a", 32'(pass_a), 32'(e.pass));
        check("busy_cycles_a", 32'(busy_cnt_a), 32'(e.cycles));
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
        check("err_cnt_a", 32'(err_a), 32'(e.err));
        check("first_fail_a", 32'(ff_a), 32'(e.ff));
`endif
        $display("sweep A: sig=%h pass=%b busy_cycles=%0d", sig_a, pass_a, busy_cnt_a);
      end
    end
    if (!busy_a) busy_cnt_a = 0;
    done_prev_a = done_a;
  end

  int   busy_cnt_b = 0;
  logic done_prev_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_b) begin
      busy_cnt_b++;
      if (stim_q_b.size() == 0) fail_now("stim_b_unexpected");
      else check("stim_b", 32'(stim_b), 32'(stim_q_b.pop_front()));
    end
    if (done_b && !done_prev_b) begin
      if (exp_q_b.size() == 0) fail_now("result_b_unexpected");
      else begin
        e = exp_q_b.pop_front();
        check("sig_b", 32'(sig_b), 32'(e.sig));
        check("pass_b", 32'(pass_b), 32'(e.pass));
        check("busy_cycles_b", 32'(busy_cnt_b), 32'(e.cycles));
`ifdef GF180MCU_OSU_SC_BIST_GOLDEN_CHECK_EN
        check("err_cnt_b", 32'(err_b), 32'(e.err));
        check("first_fail_b", 32'(ff_b), 32'(e.ff));
`endif
        $display("sweep B: sig=%h pass=%b busy_cycles=%0d", sig_b, pass_b, busy_cnt_b);
      end
    end
    if (!busy_b) busy_cnt_b = 0;
    done_prev_b = done_b;
  end

  initial begin
    logic [7:0]  tt;
    logic [15:0] es;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tt_a = 8'h01; tt_b = 8'h01; exp_sig_a = '0; exp_sig_b = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_stim", 32'(stim_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_sig", 32'(sig_a), 32'hFFFF);
    check("rst_sig_b", 32'(sig_b), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Ideal NOR2, matching expected signature, then verdict must survive EXP_SIG changes.
    launch_a(8'h01, 16'h0E17);
    start_a = 1'b0;
    wait_done_a();
    check("nor2_sig_const", 32'(sig_a), 32'h0E17);
    exp_sig_a = 16'h1234;
    @(posedge clk); #1;
    check("pass_holds_in_fin", 32'(pass_a), 1);

    launch_a(8'h01, 16'h0000);
    start_a = 1'b0;
    wait_done_a();

    launch_a(8'h00, 16'h0E17);
    start_a = 1'b0;
    wait_done_a();
    check("stuck0_sig_differs", 32'(sig_a != 16'h0E17), 1);

    // Abort during the fifth BUSY cycle.
    launch_a(8'h01, 16'h0E17);
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_stim", 32'(stim_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_done", 32'(done_a), 0);
    check("abort_sig", 32'(sig_a), 32'hFFFF);
    stim_q_a.delete();
    exp_q_a.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    launch_a(8'h01, 16'h0E17);
    start_a = 1'b0;
    wait_done_a();

    // START held: ignored while running, relaunches from FIN.
    launch_a(8'h01, 16'h0E17);
    wait_done_a();
    push_a(8'h01, 16'h0E17);
    @(posedge clk); #1;
    check("relaunch_busy", 32'(busy_a), 1);
    check("relaunch_done", 32'(done_a), 0);
    check("relaunch_sig", 32'(sig_a), 32'hFFFF);
    start_a = 1'b0;
    wait_done_a();

    for (int i = 0; i < 6; i++) begin
      tt = 8'($urandom);
      es = ($urandom_range(0, 1) == 1) ? model(2, 2, tt, 16'h0).sig : 16'($urandom);
      launch_a(tt, es);
      start_a = 1'b0;
      wait_done_a();
    end

    launch_b(8'h01, model(3, 1, 8'h01, 16'h0).sig);
    wait_done_b();
    for (int i = 0; i < 4; i++) begin
      tt = 8'($urandom);
      es = ($urandom_range(0, 1) == 1) ? model(3, 1, tt, 16'h0).sig : 16'($urandom);
      launch_b(tt, es);
      wait_done_b();
    end

    repeat (2) @(posedge clk);
    #1;
    check("results_a_drained", 32'(exp_q_a.size()), 0);
    check("results_b_drained", 32'(exp_q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
